// File: rtl/anim_pkg.sv
// Shared definitions for the animation sequencer and the renderer that
// consumes its outputs.
//   anim_state_e   : FSM state encodings (WAIT/FALL/SWALLOW; 3 is illegal)
//   DEF_*          : default geometry and dwell lengths
//   TEXT_Y_W, PHASE_W, FRAME_CNT_W : renderer-facing output widths
package anim_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        FALL    = 2'd1,
        SWALLOW = 2'd2
    } anim_state_e;

    localparam int DEF_Y_TOP       = 20;
    localparam int DEF_Y_FLOOR     = 275;
    localparam int DEF_WAIT_FRAMES = 256;
    localparam int DEF_HOLD_FRAMES = 64;

    localparam int TEXT_Y_W    = 10;
    localparam int PHASE_W     = 8;
    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/anim_sequencer_if.sv
// Per-frame animation state bus from the sequencer to the renderer.
//   frame_tick   : one-cycle pulse per frame
//   frame_cnt    : free-running frame count
//   ring_phase   : ring texture scroll phase
//   text_y       : falling-text top-edge Y
//   text_visible : text drawn when high
//   anim_state   : current sequencer state
// modport master: sequencer side (drives), modport slave: renderer side.
interface anim_sequencer_if;
    import anim_pkg::*;

    logic                   frame_tick;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [PHASE_W-1:0]     ring_phase;
    logic [TEXT_Y_W-1:0]    text_y;
    logic                   text_visible;
    logic [1:0]             anim_state;

    modport master (
        output frame_tick, frame_cnt, ring_phase, text_y, text_visible, anim_state
    );

    modport slave (
        input frame_tick, frame_cnt, ring_phase, text_y, text_visible, anim_state
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Frame boundary detector, reusable by any per-frame logic.
//   clk        : pixel clock
//   rst_n      : asynchronous active-low reset
//   vsync      : active-low vertical sync
//   tick       : combinational, high in the cycle where vsync has just risen
//   frame_tick : registered copy of tick (one cycle later, one cycle wide)
// The vsync history resets high so a vsync already high at reset release
// is not taken as a rising edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick,
    output logic frame_tick
);

    logic vs_q;

    assign tick = vsync & ~vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= vsync;
            frame_tick <= tick;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Frame-rate animation controller feeding the black-hole renderer.
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   vsync      : active-low vertical sync; its rising edge is the frame tick
//   pause      : freezes ring_phase and the state machine (frame_cnt still runs)
//   restart    : pulse; returns the text to the top at the next tick
//   speed      : fall step per frame minus one (1..4 pixels)
//   anim       : master side of the per-frame animation bus
// All state changes on the tick edge, which lies in vertical blanking, so
// the renderer never sees a change inside the active area.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int Y_TOP       = DEF_Y_TOP,
    parameter int Y_FLOOR     = DEF_Y_FLOOR,
    parameter int WAIT_FRAMES = DEF_WAIT_FRAMES,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int CNT_W       = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              pause,
    input  logic              restart,
    input  logic [1:0]        speed,
    anim_sequencer_if.master  anim
);

    localparam logic [TEXT_Y_W-1:0] Y_TOP_V   = TEXT_Y_W'(Y_TOP);
    localparam logic [TEXT_Y_W-1:0] Y_FLOOR_V = TEXT_Y_W'(Y_FLOOR);
    localparam logic [CNT_W-1:0]    WAIT_LAST = CNT_W'(WAIT_FRAMES - 1);
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);

    // One bit wider than text_y so the floor comparison cannot wrap.
    function automatic logic [TEXT_Y_W:0] fall_sum(input logic [TEXT_Y_W-1:0] y,
                                                   input logic [1:0]          spd);
        return {1'b0, y} + (TEXT_Y_W+1)'(spd) + (TEXT_Y_W+1)'(1);
    endfunction

    logic tick;

    anim_state_e            state_q,   state_d;
    logic [CNT_W-1:0]       dwell_q,   dwell_d;
    logic                   pend_q,    pend_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [PHASE_W-1:0]     ring_phase_q, ring_phase_d;
    logic [TEXT_Y_W-1:0]    text_y_q,  text_y_d;
    logic                   visible_q, visible_d;
    logic [TEXT_Y_W:0]      sum;

    frame_tick_gen u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .tick       (tick),
        .frame_tick (anim.frame_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT;
            dwell_q      <= '0;
            pend_q       <= 1'b0;
            frame_cnt_q  <= '0;
            ring_phase_q <= '0;
            text_y_q     <= Y_TOP_V;
            visible_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            pend_q       <= pend_d;
            frame_cnt_q  <= frame_cnt_d;
            ring_phase_q <= ring_phase_d;
            text_y_q     <= text_y_d;
            visible_q    <= visible_d;
        end
    end

    // Next-state logic; everything holds between ticks
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        pend_d       = pend_q | restart;
        frame_cnt_d  = frame_cnt_q;
        ring_phase_d = ring_phase_q;
        text_y_d     = text_y_q;
        visible_d    = visible_q;
        sum          = fall_sum(text_y_q, speed);

        if (tick) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            pend_d      = 1'b0;
            if (!pause) begin
                ring_phase_d = ring_phase_q + 1'b1;
            end

            // A restart pulse in the tick cycle itself counts as pending.
            if (pend_q || restart) begin
                state_d   = WAIT;
                dwell_d   = '0;
                text_y_d  = Y_TOP_V;
                visible_d = 1'b1;
            end else if (!pause) begin
                case (state_q)
                    WAIT: begin
                        text_y_d  = Y_TOP_V;
                        visible_d = 1'b1;
                        if (dwell_q == WAIT_LAST) begin
                            dwell_d = '0;
                            state_d = FALL;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                    FALL: begin
                        if (sum >= (TEXT_Y_W+1)'(Y_FLOOR)) begin
                            text_y_d  = Y_FLOOR_V;
                            visible_d = 1'b0;
                            state_d   = SWALLOW;
                        end else begin
                            text_y_d = sum[TEXT_Y_W-1:0];
                        end
                    end
                    SWALLOW: begin
                        visible_d = 1'b0;
                        text_y_d  = Y_FLOOR_V;
                        if (dwell_q == HOLD_LAST) begin
                            dwell_d   = '0;
                            text_y_d  = Y_TOP_V;
                            visible_d = 1'b1;
                            state_d   = WAIT;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d   = WAIT;
                        dwell_d   = '0;
                        text_y_d  = Y_TOP_V;
                        visible_d = 1'b1;
                    end
                endcase
            end
        end
    end

    assign anim.frame_cnt    = frame_cnt_q;
    assign anim.ring_phase   = ring_phase_q;
    assign anim.text_y       = text_y_q;
    assign anim.text_visible = visible_q;
    assign anim.anim_state   = state_q;

endmodule

// File: tb/tb_anim_sequencer.sv
module tb_anim_sequencer;

    localparam int WF = 4;
    localparam int HF = 2;
    localparam int YT = 20;
    localparam int YF = 275;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vsync = 1'b1;
    logic       pause = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] speed = 2'd0;

    anim_sequencer_if bus ();

    anim_sequencer #(
        .Y_TOP(YT), .Y_FLOOR(YF), .WAIT_FRAMES(WF), .HOLD_FRAMES(HF), .CNT_W(9)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vsync   (vsync),
        .pause   (pause),
        .restart (restart),
        .speed   (speed),
        .anim    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int ft_cnt = 0;

    always @(posedge clk) if (bus.frame_tick === 1'b1) ft_cnt++;

    // Reference model: animation state as described by the frame rules.
    int m_frame, m_phase, m_y, m_vis, m_state, m_dwell, m_pend;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame = 0; m_phase = 0; m_y = YT; m_vis = 1;
        m_state = 0; m_dwell = 0; m_pend = 0;
    endtask

    task automatic model_tick(input int spd, input bit pse);
        m_frame = (m_frame + 1) % 65536;
        if (!pse) m_phase = (m_phase + 1) % 256;
        if (m_pend != 0) begin
            m_state = 0; m_y = YT; m_vis = 1; m_dwell = 0;
        end else if (!pse) begin
            if (m_state == 0) begin
                if (m_dwell == WF - 1) begin m_dwell = 0; m_state = 1; end
                else m_dwell++;
            end else if (m_state == 1) begin
                if (m_y + spd + 1 >= YF) begin m_y = YF; m_vis = 0; m_state = 2; end
                else m_y = m_y + spd + 1;
            end else begin
                if (m_dwell == HF - 1) begin
                    m_dwell = 0; m_y = YT; m_vis = 1; m_state = 0;
                end else m_dwell++;
            end
        end
        m_pend = 0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".frame_cnt"},  int'(bus.frame_cnt),    m_frame);
        chk({tag, ".ring_phase"}, int'(bus.ring_phase),   m_phase);
        chk({tag, ".text_y"},     int'(bus.text_y),       m_y);
        chk({tag, ".visible"},    int'(bus.text_visible), m_vis);
        chk({tag, ".state"},      int'(bus.anim_state),   m_state);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".frame_tick"}, int'(bus.frame_tick),   0);
        chk({tag, ".frame_cnt"},  int'(bus.frame_cnt),    0);
        chk({tag, ".ring_phase"}, int'(bus.ring_phase),   0);
        chk({tag, ".text_y"},     int'(bus.text_y),       YT);
        chk({tag, ".visible"},    int'(bus.text_visible), 1);
        chk({tag, ".state"},      int'(bus.anim_state),   0);
    endtask

    // One frame: vsync low with a random mid-frame speed, optional restart
    // pulse, then the rising edge with the final speed.
    task automatic run_frame(input bit pse, input bit rst_pulse, input int spd);
        @(negedge clk);
        vsync = 1'b0;
        pause = pse;
        speed = 2'($urandom_range(0, 3));
        @(negedge clk);
        if (rst_pulse) begin
            restart = 1'b1;
            @(negedge clk);
            restart = 1'b0;
            m_pend = 1;
            chk_outputs("restart_hold");
        end
        @(negedge clk);
        speed = 2'(spd);
        vsync = 1'b1;
        model_tick(spd, pse);
        @(posedge clk); #1;
        chk("frame_tick_hi", int'(bus.frame_tick), 1);
        chk_outputs("tick");
        @(posedge clk); #1;
        chk("frame_tick_lo", int'(bus.frame_tick), 0);
    endtask

    task automatic run_until(input int st, input int y, input int spd, input string tag);
        int n;
        n = 0;
        while (!(m_state == st && (y < 0 || m_y == y)) && n < 400) begin
            run_frame(1'b0, 1'b0, spd);
            n++;
        end
        chk({tag, ".reached"}, int'(n < 400), 1);
    endtask

    initial begin
        int f0, ph0, y0, s0, ft0;

        model_reset();
        #2 rst_n = 1'b0;
        #2 chk_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_values("post_release");

        // Three frames, unpaused
        ft0 = ft_cnt;
        for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 3);
        chk("three.frame_cnt", int'(bus.frame_cnt), 3);
        chk("three.ring_phase", int'(bus.ring_phase), 3);
        chk("three.tick_pulses", ft_cnt - ft0, 3);

        // Full WAIT -> FALL -> SWALLOW -> WAIT cycle at speed 3
        run_until(2, -1, 3, "to_swallow");
        run_until(0, -1, 3, "back_to_wait");

        // Pause while falling at y=100
        run_until(1, 100, 3, "fall_100");
        f0 = int'(bus.frame_cnt); ph0 = int'(bus.ring_phase);
        y0 = int'(bus.text_y);    s0 = int'(bus.anim_state);
        for (int i = 0; i < 5; i++) run_frame(1'b1, 1'b0, 3);
        chk("pause.frame_cnt", int'(bus.frame_cnt), (f0 + 5) % 65536);
        chk("pause.ring_phase", int'(bus.ring_phase), ph0);
        chk("pause.text_y", int'(bus.text_y), y0);
        chk("pause.state", int'(bus.anim_state), s0);

        // Restart in SWALLOW while paused
        run_until(2, -1, 3, "swallow_restart");
        run_frame(1'b1, 1'b1, 3);
        chk("restart.state", int'(bus.anim_state), 0);
        chk("restart.text_y", int'(bus.text_y), YT);
        chk("restart.visible", int'(bus.text_visible), 1);
        run_until(1, -1, 3, "after_restart");

        // Counter wrap from preloaded values
        @(negedge clk);
        vsync = 1'b0;
        force dut.frame_cnt_q = 16'hFFFF;
        force dut.ring_phase_q = 8'hFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        release dut.ring_phase_q;
        m_frame = 65535; m_phase = 255;
        run_frame(1'b0, 1'b0, 0);
        chk("wrap.frame_cnt", int'(bus.frame_cnt), 0);
        chk("wrap.ring_phase", int'(bus.ring_phase), 0);

        // Asynchronous reset during FALL at y=150
        run_until(0, -1, 1, "wait_for_150");
        run_until(1, 150, 1, "fall_150");
        @(negedge clk);
        vsync = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async_reset");
        model_reset();
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        ft0 = ft_cnt;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_tick_after_release", ft_cnt - ft0, 0);
        chk_reset_values("after_release");

        // Randomized frames
        for (int i = 0; i < 250; i++) begin
            run_frame(bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 9) == 0),
                      int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
